// File: rtl/aes_ctr_pkg.sv
// Shared types and constants for the CTR block sequencer.
package aes_ctr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_XFER,
    ST_WAIT,
    ST_UNLOAD
  } seq_state_e;

  localparam int unsigned WORD_CNT_W       = 2;
  localparam int unsigned WAIT_MAX_DEFAULT = 64;

  typedef logic [WORD_CNT_W-1:0] word_cnt_t;

  // Word idx of a 128-bit block; word 0 is bits [127:96].
  function automatic logic [31:0] get_word(logic [127:0] blk, word_cnt_t idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

  // Return blk with word idx replaced by w.
  function automatic logic [127:0] put_word(logic [127:0] blk, word_cnt_t idx, logic [31:0] w);
    logic [127:0] r;
    r = blk;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctr_block_sequencer_if.sv
// Word stream, cipher-core and status signals of the CTR block sequencer.
interface ctr_block_sequencer_if;

  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_word;
  logic         core_start;
  logic [127:0] core_state;
  logic         core_done;
  logic [127:0] core_result;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_word;
  logic         busy;
  logic         err;

  // Environment side: feeds words, models the core, consumes words.
  modport master (
    output in_valid, in_word, core_done, core_result, out_ready,
    input  in_ready, core_start, core_state, out_valid, out_word, busy, err
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_word, core_done, core_result, out_ready,
    output in_ready, core_start, core_state, out_valid, out_word, busy, err
  );

endinterface

// File: rtl/state_transpose.sv
// Byte-matrix transpose: output byte 4c+r = input byte 4r+c (byte 0 = [127:120]).
module state_transpose (
  input  logic [127:0] din,
  output logic [127:0] dout
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign dout[127-8*(4*c+r) -: 8] = din[127-8*(4*r+c) -: 8];
    end
  end

endmodule

// File: rtl/ctr_block_sequencer.sv
// Gathers four 32-bit words into a block, hands it to the cipher core in
// column-major order, waits (bounded) for the result and streams it back out.
module ctr_block_sequencer
  import aes_ctr_pkg::*;
#(
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input logic                  clk,
  input logic                  rst_n,
  ctr_block_sequencer_if.slave bus
);

  localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);
  typedef logic [WAIT_W-1:0] wait_cnt_t;
  localparam wait_cnt_t WAIT_LIMIT = WAIT_W'(WAIT_MAX);
  localparam word_cnt_t WORD_LAST  = '1;

  seq_state_e   state_q, state_n;
  word_cnt_t    in_cnt_q, in_cnt_n;
  word_cnt_t    out_cnt_q, out_cnt_n;
  wait_cnt_t    wait_cnt_q, wait_cnt_n;
  logic [127:0] blk_q, blk_n;
  logic [127:0] res_q, res_n;

  logic         in_ready_q, in_ready_n;
  logic         core_start_q, core_start_n;
  logic [127:0] core_state_q, core_state_n;
  logic         out_valid_q, out_valid_n;
  logic [31:0]  out_word_q, out_word_n;
  logic         busy_q, busy_n;
  logic         err_q, err_n;

  logic         in_hs, out_hs;
  logic [127:0] load_blk, load_t, res_t;

  assign in_hs  = bus.in_valid && in_ready_q;
  assign out_hs = out_valid_q && bus.out_ready;

  // Block as it will look once the word currently offered is stored; the
  // input transpose works on this so core_state is ready in the XFER cycle.
  assign load_blk = put_word(blk_q, in_cnt_q, bus.in_word);

  state_transpose u_in_transpose (
    .din  (load_blk),
    .dout (load_t)
  );

  state_transpose u_res_transpose (
    .din  (bus.core_result),
    .dout (res_t)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_n      = state_q;
    in_cnt_n     = in_cnt_q;
    out_cnt_n    = out_cnt_q;
    wait_cnt_n   = '0;
    blk_n        = blk_q;
    res_n        = res_q;
    core_state_n = core_state_q;
    out_word_n   = out_word_q;
    err_n        = err_q;

    unique case (state_q)
      ST_IDLE: begin
        in_cnt_n  = '0;
        out_cnt_n = '0;
        if (in_hs) begin
          blk_n    = load_blk;
          in_cnt_n = word_cnt_t'(1);
          state_n  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_hs) begin
          blk_n    = load_blk;
          in_cnt_n = in_cnt_q + 1'b1;
          if (in_cnt_q == WORD_LAST) begin
            core_state_n = load_t;
            state_n      = ST_XFER;
          end
        end
      end
      ST_XFER: begin
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        wait_cnt_n = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q : wait_cnt_q + 1'b1;
        if (bus.core_done) begin
          res_n      = res_t;
          out_word_n = get_word(res_t, '0);
          state_n    = ST_UNLOAD;
        end else if (wait_cnt_n == WAIT_LIMIT) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_UNLOAD: begin
        if (out_hs) begin
          out_cnt_n = out_cnt_q + 1'b1;
          if (out_cnt_q == WORD_LAST) begin
            state_n = ST_IDLE;
          end else begin
            out_word_n = get_word(res_q, out_cnt_q + 1'b1);
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    in_ready_n   = (state_n == ST_IDLE) || (state_n == ST_LOAD);
    core_start_n = (state_n == ST_XFER);
    out_valid_n  = (state_n == ST_UNLOAD);
    busy_n       = (state_n != ST_IDLE);
  end

  // State, counters, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      blk_q        <= '0;
      res_q        <= '0;
      in_ready_q   <= 1'b0;
      core_start_q <= 1'b0;
      core_state_q <= '0;
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_n;
      in_cnt_q     <= in_cnt_n;
      out_cnt_q    <= out_cnt_n;
      wait_cnt_q   <= wait_cnt_n;
      blk_q        <= blk_n;
      res_q        <= res_n;
      in_ready_q   <= in_ready_n;
      core_start_q <= core_start_n;
      core_state_q <= core_state_n;
      out_valid_q  <= out_valid_n;
      out_word_q   <= out_word_n;
      busy_q       <= busy_n;
      err_q        <= err_n;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.core_start = core_start_q;
  assign bus.core_state = core_state_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_word   = out_word_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_ctr_block_sequencer.sv
// Randomized self-checking bench for ctr_block_sequencer with a byte-matrix
// reference model and a simple cipher-core stand-in (result = state ^ key).
module tb_ctr_block_sequencer;

  localparam int unsigned TB_WAIT_MAX = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  logic [31:0] rx_q[$];

  ctr_block_sequencer_if bus ();

  ctr_block_sequencer #(.WAIT_MAX(TB_WAIT_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Block viewed as a 4x4 byte matrix filled row by row; result is the
  // transposed matrix read back row by row.
  function automatic logic [127:0] tr_model(input logic [127:0] x);
    logic [7:0] b [16];
    logic [7:0] o [16];
    logic [127:0] y;
    for (int i = 0; i < 16; i++) b[4'(i)] = 8'(x >> (120 - 8*i));
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        o[4'(col*4 + row)] = b[4'(row*4 + col)];
    y = '0;
    for (int i = 0; i < 16; i++) y = {y[119:0], o[4'(i)]};
    return y;
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] x, input int unsigned k);
    return 32'(x >> (96 - 32*k));
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic send_word(input logic [31:0] w);
    int unsigned guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) check_val("in_ready_wait", 128'(bus.in_ready), 128'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] blk, input bit gaps);
    for (int unsigned k = 0; k < 4; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_word(word_of(blk, k));
    end
  endtask

  task automatic collect(input int unsigned stall_word, input int unsigned stall_len, input bit rnd);
    int unsigned got = 0;
    int unsigned guard = 0;
    int unsigned stall = 0;
    logic [31:0] held = '0;
    bit holding = 1'b0;
    rx_q.delete();
    while (got < 4 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (got == stall_word && stall < stall_len) begin
        bus.out_ready = 1'b0;
        stall++;
      end else begin
        bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (bus.out_valid) begin
        if (holding) check_val("out_word_hold", 128'(bus.out_word), 128'(held));
        if (bus.out_ready) begin
          rx_q.push_back(bus.out_word);
          got++;
          holding = 1'b0;
        end else begin
          held    = bus.out_word;
          holding = 1'b1;
        end
      end
    end
    if (got < 4) check_val("collect_count", 128'(got), 128'(4));
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_block(input string name, input logic [127:0] blk, input logic [127:0] key,
                           input int unsigned done_cycle, input int unsigned stall_word,
                           input int unsigned stall_len, input bit rnd);
    logic [127:0] exp_state, result, exp_out;
    exp_state = tr_model(blk);
    result    = exp_state ^ key;
    exp_out   = tr_model(result);
    send_block(blk, rnd);
    check_val({name, "_core_start"}, 128'(bus.core_start), 128'(1));
    check_val({name, "_core_state"}, bus.core_state, exp_state);
    check_val({name, "_in_ready_xfer"}, 128'(bus.in_ready), 128'(0));
    for (int unsigned j = 1; j <= done_cycle; j++) begin
      @(posedge clk);
      #1;
      if (j == 1) begin
        check_val({name, "_start_pulse"}, 128'(bus.core_start), 128'(0));
        check_val({name, "_in_ready_wait"}, 128'(bus.in_ready), 128'(0));
      end
      if (rnd) begin
        bus.in_valid = 1'b1;
        bus.in_word  = $urandom();
      end
    end
    bus.core_done   = 1'b1;
    bus.core_result = result;
    @(posedge clk);
    #1;
    bus.core_done   = 1'b0;
    bus.core_result = rand128();
    bus.in_valid    = 1'b0;
    check_val({name, "_out_valid"}, 128'(bus.out_valid), 128'(1));
    collect(stall_word, stall_len, rnd);
    for (int unsigned k = 0; k < 4; k++) begin
      if (k < rx_q.size())
        check_val($sformatf("%s_word%0d", name, k), 128'(rx_q[k]), 128'(word_of(exp_out, k)));
    end
    check_val({name, "_out_valid_end"}, 128'(bus.out_valid), 128'(0));
    check_val({name, "_busy_end"}, 128'(bus.busy), 128'(0));
    check_val({name, "_in_ready_end"}, 128'(bus.in_ready), 128'(1));
    check_val({name, "_core_state_hold"}, bus.core_state, exp_state);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic saw;
    logic [127:0] blk;
    bus.in_valid    = 1'b0;
    bus.in_word     = '0;
    bus.core_done   = 1'b0;
    bus.core_result = '0;
    bus.out_ready   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", 128'(bus.in_ready), 128'(0));
    check_val("rst_core_start", 128'(bus.core_start), 128'(0));
    check_val("rst_core_state", bus.core_state, 128'(0));
    check_val("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check_val("rst_out_word", 128'(bus.out_word), 128'(0));
    check_val("rst_busy", 128'(bus.busy), 128'(0));
    check_val("rst_err", 128'(bus.err), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("in_ready_rise", 128'(bus.in_ready), 128'(1));

    run_block("xpose", 128'h00010203_04050607_08090a0b_0c0d0e0f, '0, 3, 4, 0, 1'b0);
    run_block("bp", 128'h00010203_04050607_08090a0b_0c0d0e0f, '0, 2, 1, 5, 1'b0);
    run_block("tie", rand128(), rand128(), TB_WAIT_MAX, 4, 0, 1'b0);
    check_val("tie_err", 128'(bus.err), 128'(0));

    // core_done outside WAIT must be ignored
    @(negedge clk);
    bus.core_done   = 1'b1;
    bus.core_result = rand128();
    @(negedge clk);
    bus.core_done = 1'b0;
    @(posedge clk);
    #1;
    check_val("idle_done_busy", 128'(bus.busy), 128'(0));
    check_val("idle_done_valid", 128'(bus.out_valid), 128'(0));

    repeat (12)
      run_block("rnd", rand128(), rand128(), $urandom_range(1, TB_WAIT_MAX),
                $urandom_range(0, 3), $urandom_range(0, 4), 1'b1);

    // reset in the middle of loading
    send_word(32'h11111111);
    send_word(32'h22222222);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_in_ready", 128'(bus.in_ready), 128'(0));
    check_val("mid_rst_busy", 128'(bus.busy), 128'(0));
    check_val("mid_rst_core_state", bus.core_state, 128'(0));
    check_val("mid_rst_out_word", 128'(bus.out_word), 128'(0));
    check_val("mid_rst_core_start", 128'(bus.core_start), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      saw = saw | bus.core_start | bus.busy;
    end
    check_val("mid_rst_no_start", 128'(saw), 128'(0));
    run_block("fresh", 128'hdeadbeef_01234567_89abcdef_cafef00d, rand128(), 5, 4, 0, 1'b0);

    // timeout: core never answers
    blk = rand128();
    send_block(blk, 1'b0);
    check_val("to_core_start", 128'(bus.core_start), 128'(1));
    saw = 1'b0;
    for (int unsigned j = 0; j < TB_WAIT_MAX; j++) begin
      @(posedge clk);
      #1;
      saw = saw | bus.out_valid;
    end
    check_val("to_err_before", 128'(bus.err), 128'(0));
    check_val("to_busy_before", 128'(bus.busy), 128'(1));
    @(posedge clk);
    #1;
    saw = saw | bus.out_valid;
    check_val("to_err", 128'(bus.err), 128'(1));
    check_val("to_busy", 128'(bus.busy), 128'(0));
    check_val("to_in_ready", 128'(bus.in_ready), 128'(1));
    check_val("to_no_valid", 128'(saw), 128'(0));

    run_block("after_to", rand128(), rand128(), 4, 4, 0, 1'b0);
    check_val("err_sticky", 128'(bus.err), 128'(1));

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("err_cleared", 128'(bus.err), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
